// File: rtl/branch_predictor_bht_pkg.sv
// Branch predictor shared definitions: counter encodings,
// saturating counter helpers and PC index/tag extraction.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == ST) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == SNT) ? c : c - 2'b01;
    endfunction

    // Word index bits pc[idx_w+1:2], right-aligned.
    function automatic logic [31:0] pc_idx(
        input logic [31:0] pc,
        input int          idx_w
    );
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag bits pc[idx_w+tag_w+1:idx_w+2], right-aligned.
    function automatic logic [31:0] pc_tag(
        input logic [31:0] pc,
        input int          idx_w,
        input int          tag_w
    );
        return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Predictor bus: fetch lookup, resolved-branch update, flush, stats.
// master = pipeline side, slave = predictor side.
interface branch_predictor_bht_if #(
    parameter int CNT_W = 16
);
    import bp_pkg::*;

    logic [31:0]      if_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic             upd_mispredict;
    logic             bp_flush;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken,
        output upd_target, upd_mispredict, bp_flush,
        input  pred_hit, pred_taken, pred_target,
        input  stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken,
        input  upd_target, upd_mispredict, bp_flush,
        output pred_hit, pred_taken, pred_target,
        output stat_branches, stat_mispredicts
    );

endinterface

// File: rtl/branch_predictor_bht_entry_table.sv
// BTB/counter arrays: one combinational read port, one synchronous
// read-modify-write training port, flush clears valid and counters.
module bp_entry_table
    import bp_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter int         TAG_W    = 8,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic             rd_taken,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [31:0]      wr_target,
    input  logic             flush
);

    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr    [ENTRIES];
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [31:0]        target [ENTRIES];
    logic               wr_hit;

    assign rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
    assign rd_taken  = ctr[rd_idx][1];
    assign rd_target = target[rd_idx];
    assign wr_hit    = valid[wr_idx] && (tag[wr_idx] == wr_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= CTR_INIT;
        end else if (wr_en) begin
            if (wr_hit) begin
                ctr[wr_idx] <= wr_taken ? sat_inc(ctr[wr_idx])
                                        : sat_dec(ctr[wr_idx]);
            end else if (wr_taken) begin
                valid[wr_idx] <= 1'b1;
                ctr[wr_idx]   <= WT;
            end
        end
    end

    // Tag/target are not reset; valid gates them. Taken updates
    // (hit or allocate) rewrite both, a hit rewrites the same tag.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_en && wr_taken) begin
            tag[wr_idx]    <= wr_tag;
            target[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Bimodal/gshare branch predictor top: index hashing, global
// history, next-PC mux and saturating statistics over the bus.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter int         TAG_W    = 8,
    parameter int         HIST_W   = 0,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_predictor_bht_if.slave  bus
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0] hist;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic             rd_hit;
    logic             rd_taken;
    logic [31:0]      rd_target;
    logic             upd_ok;
    logic [CNT_W-1:0] n_br;
    logic [CNT_W-1:0] n_mp;

    // Flush wins over a same-cycle update, statistics included.
    assign upd_ok = bus.upd_valid && !bus.bp_flush;

    assign rd_idx = IDX_W'(pc_idx(bus.if_pc, IDX_W)) ^ hist;
    assign rd_tag = TAG_W'(pc_tag(bus.if_pc, IDX_W, TAG_W));
    assign wr_idx = IDX_W'(pc_idx(bus.upd_pc, IDX_W)) ^ hist;
    assign wr_tag = TAG_W'(pc_tag(bus.upd_pc, IDX_W, TAG_W));

    bp_entry_table #(
        .ENTRIES  (ENTRIES),
        .TAG_W    (TAG_W),
        .CTR_INIT (CTR_INIT),
        .IDX_W    (IDX_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (rd_idx),
        .rd_tag    (rd_tag),
        .rd_hit    (rd_hit),
        .rd_taken  (rd_taken),
        .rd_target (rd_target),
        .wr_en     (upd_ok),
        .wr_idx    (wr_idx),
        .wr_tag    (wr_tag),
        .wr_taken  (bus.upd_taken),
        .wr_target (bus.upd_target),
        .flush     (bus.bp_flush)
    );

    if (HIST_W > 0) begin : g_gshare
        logic [HIST_W-1:0] ghr;

        // Truncating cast keeps the shift valid for HIST_W == 1.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                ghr <= '0;
            else if (bus.bp_flush)
                ghr <= '0;
            else if (bus.upd_valid)
                ghr <= HIST_W'({ghr, bus.upd_taken});
        end

        assign hist = IDX_W'(ghr);
    end else begin : g_bimodal
        assign hist = '0;
    end

    assign bus.pred_hit    = rd_hit;
    assign bus.pred_taken  = rd_hit && rd_taken;
    assign bus.pred_target = bus.pred_taken ? rd_target
                                            : bus.if_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_br <= '0;
            n_mp <= '0;
        end else if (upd_ok) begin
            if (!(&n_br))
                n_br <= n_br + CNT_W'(1);
            if (bus.upd_mispredict && !(&n_mp))
                n_mp <= n_mp + CNT_W'(1);
        end
    end

    assign bus.stat_branches    = n_br;
    assign bus.stat_mispredicts = n_mp;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench: bimodal instance driven from a vector table,
// gshare instance (CNT_W=2) through hand-written sequences.
module tb_branch_predictor_bht;

    typedef struct {
        logic        fl;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        um;
        logic [31:0] lpc;
        logic        eh;
        logic        et;
        logic [31:0] etg;
        logic [15:0] esb;
        logic [15:0] esm;
    } vec_t;

    typedef struct {
        logic        eh;
        logic        et;
        logic [31:0] etg;
        logic [15:0] esb;
        logic [15:0] esm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    vec_t v[15];

    always #5 clk = ~clk;

    branch_predictor_bht_if #(.CNT_W(16)) b0 ();
    branch_predictor_bht_if #(.CNT_W(2))  b1 ();

    branch_predictor_bht #(
        .ENTRIES(16), .TAG_W(8), .HIST_W(0),
        .CTR_INIT(2'b01), .CNT_W(16)
    ) d0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    branch_predictor_bht #(
        .ENTRIES(16), .TAG_W(8), .HIST_W(2),
        .CTR_INIT(2'b01), .CNT_W(2)
    ) d1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic push(input logic eh, input logic et,
                        input logic [31:0] etg,
                        input logic [15:0] esb, input logic [15:0] esm);
        exp_t e;
        e.eh = eh; e.et = et; e.etg = etg; e.esb = esb; e.esm = esm;
        sbq.push_back(e);
    endtask

    task automatic pop0(input string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sbq.pop_front();
        chk({nm, " hit"},    32'(b0.pred_hit),    32'(e.eh));
        chk({nm, " taken"},  32'(b0.pred_taken),  32'(e.et));
        chk({nm, " target"}, b0.pred_target,      e.etg);
        chk({nm, " nbr"},    32'(b0.stat_branches),    32'(e.esb));
        chk({nm, " nmp"},    32'(b0.stat_mispredicts), 32'(e.esm));
    endtask

    task automatic pop1(input string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sbq.pop_front();
        chk({nm, " hit"},    32'(b1.pred_hit),    32'(e.eh));
        chk({nm, " taken"},  32'(b1.pred_taken),  32'(e.et));
        chk({nm, " target"}, b1.pred_target,      e.etg);
        chk({nm, " nbr"},    32'(b1.stat_branches),    32'(e.esb));
        chk({nm, " nmp"},    32'(b1.stat_mispredicts), 32'(e.esm));
    endtask

    task automatic idle0();
        b0.upd_valid = 0; b0.upd_pc = '0; b0.upd_taken = 0;
        b0.upd_target = '0; b0.upd_mispredict = 0; b0.bp_flush = 0;
    endtask

    task automatic idle1();
        b1.upd_valid = 0; b1.upd_pc = '0; b1.upd_taken = 0;
        b1.upd_target = '0; b1.upd_mispredict = 0; b1.bp_flush = 0;
    endtask

    task automatic step1(input logic fl, input logic uv,
                         input logic [31:0] pc, input logic t,
                         input logic [31:0] tg, input logic m);
        @(negedge clk);
        b1.bp_flush = fl; b1.upd_valid = uv; b1.upd_pc = pc;
        b1.upd_taken = t; b1.upd_target = tg; b1.upd_mispredict = m;
        @(posedge clk);
        #1 idle1();
    endtask

    task automatic look1(input string nm, input logic [31:0] pc,
                         input logic eh, input logic et,
                         input logic [31:0] etg,
                         input logic [15:0] esb, input logic [15:0] esm);
        push(eh, et, etg, esb, esm);
        b1.if_pc = pc;
        #1 pop1(nm);
    endtask

    initial begin
        v[0]  = '{0,0,32'h0,0,32'h0,0, 32'h00400010,
                  0,0,32'h00400014, 0,0};
        v[1]  = '{0,1,32'h00400020,1,32'h00400100,1, 32'h00400020,
                  1,1,32'h00400100, 1,1};
        v[2]  = '{0,1,32'h00400020,0,32'h0,1, 32'h00400020,
                  1,0,32'h00400024, 2,2};
        v[3]  = '{0,1,32'h00400020,0,32'h0,1, 32'h00400020,
                  1,0,32'h00400024, 3,3};
        v[4]  = '{0,1,32'h00400020,0,32'h0,1, 32'h00400020,
                  1,0,32'h00400024, 4,4};
        v[5]  = '{0,1,32'h00400020,1,32'h00400100,1, 32'h00400020,
                  1,0,32'h00400024, 5,5};
        v[6]  = '{0,1,32'h00400020,1,32'h00400100,0, 32'h00400020,
                  1,1,32'h00400100, 6,5};
        v[7]  = '{0,1,32'h00400420,1,32'h00400200,0, 32'h00400020,
                  0,0,32'h00400024, 7,5};
        v[8]  = '{0,0,32'h0,0,32'h0,0, 32'h00400420,
                  1,1,32'h00400200, 7,5};
        v[9]  = '{0,1,32'h00400420,0,32'h0,1, 32'h00400420,
                  1,0,32'h00400424, 8,6};
        v[10] = '{0,0,32'h0,0,32'h0,1, 32'h00400424,
                  0,0,32'h00400428, 8,6};
        v[11] = '{1,1,32'h00400030,1,32'h00400700,1, 32'h00400420,
                  0,0,32'h00400424, 8,6};
        v[12] = '{0,1,32'h00400030,0,32'h0,0, 32'h00400030,
                  0,0,32'h00400034, 9,6};
        v[13] = '{0,1,32'h00400420,1,32'h00400300,0, 32'h00400420,
                  1,1,32'h00400300, 10,6};
        v[14] = '{0,0,32'h0,0,32'h0,0, 32'hFFFFFFFC,
                  0,0,32'h00000000, 10,6};

        idle0();
        idle1();
        b0.if_pc = 32'h00400010;
        b1.if_pc = 32'h00400010;

        #12;
        push(0, 0, 32'h00400014, 0, 0);
        pop0("in_reset");
        push(0, 0, 32'h00400014, 0, 0);
        pop1("gs_in_reset");

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            b0.bp_flush = v[i].fl;
            b0.upd_valid = v[i].uv;
            b0.upd_pc = v[i].upc;
            b0.upd_taken = v[i].ut;
            b0.upd_target = v[i].utg;
            b0.upd_mispredict = v[i].um;
            push(v[i].eh, v[i].et, v[i].etg, v[i].esb, v[i].esm);
            @(posedge clk);
            #1 idle0();
            b0.if_pc = v[i].lpc;
            #1 pop0($sformatf("vec%0d", i));
        end

        // gshare: build ghr = 11 with three taken branches
        step1(0, 1, 32'h00400104, 1, 32'h00400900, 0);
        step1(0, 1, 32'h00400108, 1, 32'h00400900, 0);
        step1(0, 1, 32'h0040010C, 1, 32'h00400900, 0);

        // same-cycle lookup of the slot being allocated sees old data
        @(negedge clk);
        b1.upd_valid = 1; b1.upd_pc = 32'h00400020;
        b1.upd_taken = 1; b1.upd_target = 32'h00400100;
        b1.if_pc = 32'h00400020;
        push(0, 0, 32'h00400024, 3, 0);
        #1 pop1("gs_same_cycle");
        @(posedge clk);
        #1 idle1();

        look1("gs_idx11", 32'h00400020, 1, 1, 32'h00400100, 3, 0);

        // flush collides with a mispredicting update
        step1(1, 1, 32'h00400020, 1, 32'h00400800, 1);
        look1("gs_flush", 32'h00400020, 0, 0, 32'h00400024, 3, 0);

        // ghr cleared: allocate at 8^0, then 0x24 with ghr=01 maps to 8
        step1(0, 1, 32'h00400020, 1, 32'h00400500, 0);
        look1("gs_ghr0", 32'h00400024, 1, 1, 32'h00400500, 3, 0);

        for (int k = 1; k <= 5; k++) begin
            step1(0, 1, 32'h00400040, 0, 32'h0, 1);
            push(0, 0, 32'h00400044, 3, (k > 3) ? 16'd3 : 16'(k));
            b1.if_pc = 32'h00400040;
            #1 pop1($sformatf("gs_mp_sat%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
